// File: rtl/stars_select_pkg.sv
// Shared types and helpers for the GPIO pad-ring design switch controller.
package stars_select_pkg;

   localparam int unsigned NUM_DESIGNS = 12;
   localparam int unsigned SEL_W       = 4;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      HOLD_RST,
      RELEASE
   } switch_state_t;

   // Map any out-of-range request (0 or above NUM_DESIGNS) to "no design".
   function automatic logic [SEL_W-1:0] sanitize_select(input logic [SEL_W-1:0] req);
      logic [SEL_W-1:0] res;
      res = '0;
      if ((req != '0) && (req <= SEL_W'(NUM_DESIGNS))) begin
         res = req;
      end
      return res;
   endfunction

   // One-hot decode into the [NUM_DESIGNS:1] per-design vector; select 0 gives all zeros.
   function automatic logic [NUM_DESIGNS:1] select_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_DESIGNS:1] oh;
      oh = '0;
      for (int unsigned i = 1; i <= NUM_DESIGNS; i++) begin
         oh[i] = (sel == SEL_W'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/design_switch_controller_filter.sv
// Debounces the sanitized design request: cand follows the request, stable
// asserts once it has been unchanged for STABLE_CYCLES further edges.
module select_stability_filter
   import stars_select_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [SEL_W-1:0] req,
   output logic [SEL_W-1:0] cand,
   output logic             stable
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

   logic [SEL_W-1:0] san_c;
   logic [SEL_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // Restart the count on any change, otherwise saturate.
   always_comb begin
      san_c    = sanitize_select(req);
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      if (san_c != cand_q) begin
         cand_d = san_c;
         cnt_d  = '0;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      stable_d = (cnt_d == CNT_SAT);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign cand   = cand_q;
   assign stable = stable_q;

endmodule

// File: rtl/design_switch_controller.sv
// Sequences safe hand-over of the shared GPIO pads between student designs:
// drain with pads forced to input, hold the new design in reset, then release.
module design_switch_controller
   import stars_select_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned DRAIN_CYCLES  = 8,
   parameter int unsigned RESET_CYCLES  = 16
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [SEL_W-1:0]     design_select_req,
   output logic [SEL_W-1:0]     active_select,
   output logic [NUM_DESIGNS:1] designs_cs,
   output logic [NUM_DESIGNS:1] designs_n_rst,
   output logic                 gpio_force_input,
   output logic                 busy,
   output logic                 switch_done
);

   localparam int unsigned PHASE_MAX = (DRAIN_CYCLES > RESET_CYCLES) ? DRAIN_CYCLES : RESET_CYCLES;
   localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
   localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(DRAIN_CYCLES - 1);
   localparam logic [PHASE_W-1:0] RESET_LAST = PHASE_W'(RESET_CYCLES - 1);

   logic [SEL_W-1:0]     cand;
   logic                 stable;

   switch_state_t        state_q, state_d;
   logic [SEL_W-1:0]     target_q, target_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [SEL_W-1:0]     active_q, active_d;
   logic [NUM_DESIGNS:1] cs_q, cs_d;
   logic [NUM_DESIGNS:1] nrst_q, nrst_d;
   logic                 force_q, force_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   select_stability_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .n_rst  (n_rst),
      .req    (design_select_req),
      .cand   (cand),
      .stable (stable)
   );

   // Next-state and output decode; target is frozen once a sequence starts.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      phase_d  = phase_q;
      active_d = active_q;
      cs_d     = cs_q;
      nrst_d   = nrst_q;
      force_d  = force_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE, ACTIVE: begin
            if (stable && (cand != active_q)) begin
               target_d = cand;
               cs_d     = '1;
               nrst_d   = '0;
               active_d = '0;
               force_d  = 1'b1;
               busy_d   = 1'b1;
               phase_d  = '0;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (phase_q == DRAIN_LAST) begin
               phase_d = '0;
               if (target_q == '0) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cs_d    = ~select_onehot(target_q);
                  state_d = HOLD_RST;
               end
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         HOLD_RST: begin
            if (phase_q == RESET_LAST) begin
               phase_d = '0;
               nrst_d  = select_onehot(target_q);
               state_d = RELEASE;
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         RELEASE: begin
            active_d = target_q;
            force_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = ACTIVE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         target_q <= '0;
         phase_q  <= '0;
         active_q <= '0;
         cs_q     <= '1;
         nrst_q   <= '0;
         force_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         phase_q  <= phase_d;
         active_q <= active_d;
         cs_q     <= cs_d;
         nrst_q   <= nrst_d;
         force_q  <= force_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign active_select    = active_q;
   assign designs_cs       = cs_q;
   assign designs_n_rst    = nrst_q;
   assign gpio_force_input = force_q;
   assign busy             = busy_q;
   assign switch_done      = done_q;

endmodule

// File: tb/tb_design_switch_controller.sv
// Scenario tasks plus a per-cycle comparison against a time-since-request
// reference model of the switch sequence and the pad-safety invariants.
module tb_design_switch_controller;

   localparam int NUM    = 12;
   localparam int STABLE = 4;
   localparam int DRAIN  = 8;
   localparam int RESET  = 16;

   logic            clk;
   logic            n_rst;
   logic [3:0]      design_select_req;
   logic [3:0]      active_select;
   logic [NUM:1]    designs_cs;
   logic [NUM:1]    designs_n_rst;
   logic            gpio_force_input;
   logic            busy;
   logic            switch_done;

   int n_checks = 0;
   int n_fail   = 0;
   int rel_e    = -1;
   bit mon_en   = 0;

   // Reference model state: seq = edges since DRAIN entry, -1 when settled.
   int m_cand = 0, m_age = 0, m_active = 0, m_target = 0, m_seq = -1;
   bit m_done = 0;
   bit m_stable;
   int m_prev_cand, m_san;

   logic [NUM:1] e_cs, e_nrst, ex_vec;
   int           e_cs_sel, e_nrst_sel;

   design_switch_controller dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .design_select_req (design_select_req),
      .active_select     (active_select),
      .designs_cs        (designs_cs),
      .designs_n_rst     (designs_n_rst),
      .gpio_force_input  (gpio_force_input),
      .busy              (busy),
      .switch_done       (switch_done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!n_rst) begin
         m_cand = 0; m_age = 0; m_active = 0; m_target = 0; m_seq = -1; m_done = 0;
      end else begin
         m_stable    = (m_age == STABLE);
         m_prev_cand = m_cand;
         m_san = (design_select_req >= 1 && design_select_req <= NUM) ? int'(design_select_req) : 0;
         if (m_san != m_cand) begin
            m_cand = m_san;
            m_age  = 0;
         end else if (m_age < STABLE) begin
            m_age++;
         end
         m_done = 0;
         if (m_seq < 0) begin
            if (m_stable && m_prev_cand != m_active) begin
               m_target = m_prev_cand;
               m_active = 0;
               m_seq    = 0;
            end
         end else begin
            m_seq++;
            if (m_target == 0 && m_seq == DRAIN) begin
               m_seq = -1; m_done = 1;
            end else if (m_target != 0 && m_seq == DRAIN + RESET + 1) begin
               m_active = m_target; m_seq = -1; m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         e_cs_sel   = (m_seq < 0) ? m_active : ((m_seq >= DRAIN) ? m_target : 0);
         e_nrst_sel = (m_seq < 0) ? m_active : ((m_seq >= DRAIN + RESET) ? m_target : 0);
         e_cs   = '1;
         e_nrst = '0;
         if (e_cs_sel != 0) e_cs[e_cs_sel] = 1'b0;
         if (e_nrst_sel != 0) e_nrst[e_nrst_sel] = 1'b1;
         n_checks++;
         if ({active_select, designs_cs, designs_n_rst, gpio_force_input, busy, switch_done} !==
             {4'(m_active), e_cs, e_nrst, (m_active == 0), (m_seq >= 0), m_done}) begin
            n_fail++;
            $display("FAIL model t=%0t: act=%0d cs=%h nrst=%h frc=%0b busy=%0b done=%0b want act=%0d cs=%h nrst=%h frc=%0b busy=%0b done=%0b",
                     $time, active_select, designs_cs, designs_n_rst, gpio_force_input, busy, switch_done,
                     m_active, e_cs, e_nrst, (m_active == 0), (m_seq >= 0), m_done);
         end
         n_checks++;
         if ($countones(~designs_cs) > 1 || $countones(designs_n_rst) > 1 ||
             (designs_n_rst & designs_cs) != '0 ||
             (active_select != 0 && (gpio_force_input !== 1'b0 || active_select > NUM ||
                                     designs_n_rst[active_select] !== 1'b1))) begin
            n_fail++;
            $display("FAIL invariant t=%0t: act=%0d cs=%h nrst=%h frc=%0b",
                     $time, active_select, designs_cs, designs_n_rst, gpio_force_input);
         end
      end
   end

   // Advance to just after request-relative edge k and sample there.
   task automatic adv(input int k);
      repeat (k - rel_e) @(posedge clk);
      @(negedge clk);
      #1;
      rel_e = k;
   endtask

   task automatic test_reset();
      int pulses;
      n_rst = 0;
      design_select_req = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      mon_en = 1;
      n_checks++; if (active_select !== 4'd0) begin n_fail++; $display("FAIL rst_active: got %0d want 0", active_select); end
      n_checks++; if (designs_cs !== 12'hFFF) begin n_fail++; $display("FAIL rst_cs: got %h want fff", designs_cs); end
      n_checks++; if (designs_n_rst !== 12'h000) begin n_fail++; $display("FAIL rst_nrst: got %h want 000", designs_n_rst); end
      n_checks++; if ({gpio_force_input, busy, switch_done} !== 3'b100) begin n_fail++; $display("FAIL rst_flags: got %b want 100", {gpio_force_input, busy, switch_done}); end
      n_rst = 1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (switch_done === 1'b1) pulses++;
      end
      n_checks++; if (busy !== 1'b0 || designs_cs !== 12'hFFF || gpio_force_input !== 1'b1) begin n_fail++; $display("FAIL idle_hold: busy=%0b cs=%h frc=%0b want 0 fff 1", busy, designs_cs, gpio_force_input); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL idle_no_done: got %0d pulses want 0", pulses); end
   endtask

   task automatic test_first_switch();
      design_select_req = 4'd4; rel_e = -1;
      adv(4);  n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw4_e4_busy: got %0b want 0", busy); end
      adv(5);  n_checks++; if (busy !== 1'b1 || gpio_force_input !== 1'b1) begin n_fail++; $display("FAIL sw4_e5_drain: busy=%0b frc=%0b want 1 1", busy, gpio_force_input); end
      adv(12); n_checks++; if (designs_cs !== 12'hFFF) begin n_fail++; $display("FAIL sw4_e12_cs: got %h want fff", designs_cs); end
      adv(13); ex_vec = '1; ex_vec[4] = 1'b0;
      n_checks++; if (designs_cs !== ex_vec || designs_n_rst !== 12'h000) begin n_fail++; $display("FAIL sw4_e13: cs=%h nrst=%h want %h 000", designs_cs, designs_n_rst, ex_vec); end
      adv(28); n_checks++; if (designs_n_rst !== 12'h000) begin n_fail++; $display("FAIL sw4_e28_nrst: got %h want 000", designs_n_rst); end
      adv(29); ex_vec = '0; ex_vec[4] = 1'b1;
      n_checks++; if (designs_n_rst !== ex_vec || active_select !== 4'd0) begin n_fail++; $display("FAIL sw4_e29: nrst=%h act=%0d want %h 0", designs_n_rst, active_select, ex_vec); end
      adv(30); n_checks++; if (active_select !== 4'd4 || gpio_force_input !== 1'b0 || switch_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sw4_e30: act=%0d frc=%0b done=%0b busy=%0b want 4 0 1 0", active_select, gpio_force_input, switch_done, busy); end
      adv(31); n_checks++; if (switch_done !== 1'b0) begin n_fail++; $display("FAIL sw4_e31_done: got %0b want 0", switch_done); end
   endtask

   task automatic test_switch_4_to_9();
      design_select_req = 4'd9; rel_e = -1;
      adv(5);  n_checks++; if (designs_cs !== 12'hFFF || designs_n_rst !== 12'h000 || active_select !== 4'd0) begin n_fail++; $display("FAIL sw9_e5: cs=%h nrst=%h act=%0d want fff 000 0", designs_cs, designs_n_rst, active_select); end
      adv(13); ex_vec = '1; ex_vec[9] = 1'b0;
      n_checks++; if (designs_cs !== ex_vec) begin n_fail++; $display("FAIL sw9_e13_cs: got %h want %h", designs_cs, ex_vec); end
      adv(29); ex_vec = '0; ex_vec[9] = 1'b1;
      n_checks++; if (designs_n_rst !== ex_vec) begin n_fail++; $display("FAIL sw9_e29_nrst: got %h want %h", designs_n_rst, ex_vec); end
      adv(30); n_checks++; if (active_select !== 4'd9 || switch_done !== 1'b1) begin n_fail++; $display("FAIL sw9_e30: act=%0d done=%0b want 9 1", active_select, switch_done); end
      design_select_req = 4'd4; rel_e = -1;
      adv(34); n_checks++; if (active_select !== 4'd4) begin n_fail++; $display("FAIL back_to_4: act=%0d want 4", active_select); end
   endtask

   task automatic test_toggle();
      int changes;
      changes = 0;
      ex_vec = '1; ex_vec[4] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         design_select_req = (i % 2 == 0) ? 4'd7 : 4'd4;
         for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (active_select !== 4'd4 || busy !== 1'b0 || switch_done !== 1'b0 || designs_cs !== ex_vec) changes++;
         end
      end
      design_select_req = 4'd4;
      repeat (10) begin
         @(negedge clk); #1;
         if (active_select !== 4'd4 || busy !== 1'b0 || switch_done !== 1'b0 || designs_cs !== ex_vec) changes++;
      end
      n_checks++; if (changes != 0) begin n_fail++; $display("FAIL toggle_const: %0d disturbed cycles want 0", changes); end
   endtask

   task automatic test_queued_request();
      design_select_req = 4'd3; rel_e = -1;
      adv(15); ex_vec = '1; ex_vec[3] = 1'b0;
      n_checks++; if (busy !== 1'b1 || designs_cs !== ex_vec) begin n_fail++; $display("FAIL q_e15: busy=%0b cs=%h want 1 %h", busy, designs_cs, ex_vec); end
      design_select_req = 4'd15;
      adv(30); n_checks++; if (active_select !== 4'd3 || switch_done !== 1'b1) begin n_fail++; $display("FAIL q_e30: act=%0d done=%0b want 3 1", active_select, switch_done); end
      adv(31); n_checks++; if (active_select !== 4'd0 || busy !== 1'b1 || gpio_force_input !== 1'b1) begin n_fail++; $display("FAIL q_e31: act=%0d busy=%0b frc=%0b want 0 1 1", active_select, busy, gpio_force_input); end
      adv(39); n_checks++; if (switch_done !== 1'b1 || busy !== 1'b0 || designs_cs !== 12'hFFF || gpio_force_input !== 1'b1) begin n_fail++; $display("FAIL q_e39: done=%0b busy=%0b cs=%h frc=%0b want 1 0 fff 1", switch_done, busy, designs_cs, gpio_force_input); end
      adv(45); n_checks++; if (busy !== 1'b0 || active_select !== 4'd0) begin n_fail++; $display("FAIL q_e45_idle: busy=%0b act=%0d want 0 0", busy, active_select); end
   endtask

   task automatic test_mid_reset();
      design_select_req = 4'd6; rel_e = -1;
      adv(19); n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mr_e19_busy: got %0b want 1", busy); end
      n_rst = 0;
      adv(20);
      n_checks++; if ({active_select, designs_cs, designs_n_rst, gpio_force_input, busy, switch_done} !== {4'd0, 12'hFFF, 12'h000, 3'b100}) begin n_fail++; $display("FAIL mr_reset: act=%0d cs=%h nrst=%h flags=%b want 0 fff 000 100", active_select, designs_cs, designs_n_rst, {gpio_force_input, busy, switch_done}); end
      n_rst = 1; rel_e = -1;
      adv(29); n_checks++; if (active_select !== 4'd0 || designs_n_rst[6] !== 1'b1) begin n_fail++; $display("FAIL mr_e29: act=%0d nrst=%h want 0 with bit6", active_select, designs_n_rst); end
      adv(30); n_checks++; if (active_select !== 4'd6 || switch_done !== 1'b1) begin n_fail++; $display("FAIL mr_e30: act=%0d done=%0b want 6 1", active_select, switch_done); end
   endtask

   task automatic test_random();
      int hold;
      for (int ep = 0; ep < 60; ep++) begin
         design_select_req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, NUM));
         hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 45);
         repeat (hold) begin
            @(negedge clk); #1;
            n_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         end
         n_rst = 1;
      end
      repeat (50) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_switch();
      test_switch_4_to_9();
      test_toggle();
      test_queued_request();
      test_mid_reset();
      test_random();
      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
